// File: rtl/fft_in_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_in_packer_if
//  Description : Bundle of the sample-stream input and block output signals of
//                fft_in_packer.
//                  in_valid / in_sync / in_i / in_q    : one complex sample per
//                                                        cycle, sync marks
//                                                        sample 0 of a frame
//                  valid_out / dout_i / dout_q         : N-wide block strobe
//                  frame_start / blk_idx / sync_err    : frame tracking status
//                master modport : the upstream source / block consumer side
//                slave modport  : the packer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_in_packer_if #(
    parameter int IN_BIT_WIDTH = 11,
    parameter int N            = 16,
    parameter int FRAME_LEN    = 512
);
    localparam int c_BLOCKS = FRAME_LEN / N;
    localparam int c_BLK_W  = (c_BLOCKS > 1) ? $clog2(c_BLOCKS) : 1;

    // Sample stream
    logic                           in_valid;
    logic                           in_sync;
    logic signed [IN_BIT_WIDTH-1:0] in_i;
    logic signed [IN_BIT_WIDTH-1:0] in_q;

    // Block output
    logic                           valid_out;
    logic signed [IN_BIT_WIDTH-1:0] dout_i [0:N-1];
    logic signed [IN_BIT_WIDTH-1:0] dout_q [0:N-1];
    logic                           frame_start;
    logic [c_BLK_W-1:0]             blk_idx;
    logic                           sync_err;

    modport master (
        output in_valid, in_sync, in_i, in_q,
        input  valid_out, dout_i, dout_q, frame_start, blk_idx, sync_err
    );

    modport slave (
        input  in_valid, in_sync, in_i, in_q,
        output valid_out, dout_i, dout_q, frame_start, blk_idx, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/fft_in_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_in_packer
//  Description : Serial-to-parallel input stage for the first FFT stage.
//                Packs N consecutive complex samples into one N-wide block,
//                presented with a single-cycle valid strobe. A sync marker
//                aligns frames of FRAME_LEN points; the block position inside
//                the frame is reported and alignment violations are flagged.
//  Ports       : clk         - rising-edge clock
//                rst         - asynchronous active-high reset
//                bus (slave) - in_valid/in_sync/in_i/in_q sample input,
//                              valid_out/dout_i/dout_q block output,
//                              frame_start/blk_idx/sync_err status
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_in_packer #(
    parameter int IN_BIT_WIDTH = 11,
    parameter int N            = 16,
    parameter int FRAME_LEN    = 512
) (
    input  logic           clk,
    input  logic           rst,
    fft_in_packer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BLOCKS = FRAME_LEN / N;
    localparam int c_BLK_W  = (c_BLOCKS > 1) ? $clog2(c_BLOCKS) : 1;
    localparam int c_SLOT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(N - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);
    localparam logic [c_BLK_W-1:0]  c_BLK_LAST  = c_BLK_W'(c_BLOCKS - 1);

    typedef enum logic [0:0] {
        ST_WAIT_SYNC = 1'b0,
        ST_RUN       = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                         r_state;
    logic [c_SLOT_W-1:0]            r_slot_cnt;
    logic [c_BLK_W-1:0]             r_blk_cnt;

    // Fill registers only hold slots 0..N-2: the last sample of a block is
    // taken straight from the input when the block is transferred.
    logic signed [IN_BIT_WIDTH-1:0] r_fill_i [0:N-2];
    logic signed [IN_BIT_WIDTH-1:0] r_fill_q [0:N-2];

    logic signed [IN_BIT_WIDTH-1:0] r_dout_i [0:N-1];
    logic signed [IN_BIT_WIDTH-1:0] r_dout_q [0:N-1];
    logic                           r_valid_out;
    logic                           r_frame_start;
    logic [c_BLK_W-1:0]             r_blk_idx;
    logic                           r_sync_err;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    state_t                         w_state_nxt;
    logic [c_SLOT_W-1:0]            w_slot_nxt;
    logic [c_BLK_W-1:0]             w_blk_nxt;
    logic                           w_fill_we;
    logic [c_SLOT_W-1:0]            w_fill_sel;
    logic                           w_emit;
    logic                           w_err;
    logic                           w_frame_head;
    logic signed [IN_BIT_WIDTH-1:0] w_blk_i [0:N-1];
    logic signed [IN_BIT_WIDTH-1:0] w_blk_q [0:N-1];

    // Position where the sync marker is mandatory: first sample of a frame.
    assign w_frame_head = (r_slot_cnt == '0) && (r_blk_cnt == '0);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot_cnt;
        w_blk_nxt   = r_blk_cnt;
        w_fill_we   = 1'b0;
        w_fill_sel  = '0;
        w_emit      = 1'b0;
        w_err       = 1'b0;

        // Without in_valid nothing moves: gaps of any length are transparent.
        if (bus.in_valid) begin
            case (r_state)
                ST_WAIT_SYNC: begin
                    // Unsynced samples are dropped until a marker arrives.
                    if (bus.in_sync) begin
                        w_fill_we   = 1'b1;
                        w_fill_sel  = '0;
                        w_slot_nxt  = c_SLOT_ONE;
                        w_blk_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (w_frame_head && !bus.in_sync) begin
                        // Missing marker: drop the sample and re-acquire.
                        w_err       = 1'b1;
                        w_state_nxt = ST_WAIT_SYNC;
                    end else if (!w_frame_head && bus.in_sync) begin
                        // Mid-frame resync: abandon the partial block and
                        // start a new frame with this sample. This takes
                        // priority over completing a block in the same cycle.
                        w_err      = 1'b1;
                        w_fill_we  = 1'b1;
                        w_fill_sel = '0;
                        w_slot_nxt = c_SLOT_ONE;
                        w_blk_nxt  = '0;
                    end else if (r_slot_cnt == c_SLOT_LAST) begin
                        // Last sample of the block: transfer to outputs.
                        w_emit     = 1'b1;
                        w_slot_nxt = '0;
                        w_blk_nxt  = (r_blk_cnt == c_BLK_LAST) ? '0
                                                               : r_blk_cnt + 1'b1;
                    end else begin
                        w_fill_we  = 1'b1;
                        w_fill_sel = r_slot_cnt;
                        w_slot_nxt = r_slot_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = ST_WAIT_SYNC;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Slot / block counters and status strobes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt    <= '0;
            r_blk_cnt     <= '0;
            r_valid_out   <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_start <= 1'b0;
            r_blk_idx     <= '0;
        end else begin
            r_slot_cnt  <= w_slot_nxt;
            r_blk_cnt   <= w_blk_nxt;
            r_valid_out <= w_emit;
            r_sync_err  <= w_err;
            // Block status is held alongside the data until the next block.
            if (w_emit) begin
                r_frame_start <= (r_blk_cnt == '0);
                r_blk_idx     <= r_blk_cnt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fill registers, one per slot 0..N-2
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N - 1; k++) begin : g_fill
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_fill_i[k] <= '0;
                r_fill_q[k] <= '0;
            end else if (w_fill_we && (w_fill_sel == c_SLOT_W'(k))) begin
                r_fill_i[k] <= bus.in_i;
                r_fill_q[k] <= bus.in_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Completed block: fill slots plus the sample being accepted now
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N; k++) begin : g_blk
        if (k < N - 1) begin : g_from_fill
            assign w_blk_i[k] = r_fill_i[k];
            assign w_blk_q[k] = r_fill_q[k];
        end else begin : g_from_input
            assign w_blk_i[k] = bus.in_i;
            assign w_blk_q[k] = bus.in_q;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers, separate from the fill so the next block fills freely
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N; k++) begin : g_out
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout_i[k] <= '0;
                r_dout_q[k] <= '0;
            end else if (w_emit) begin
                r_dout_i[k] <= w_blk_i[k];
                r_dout_q[k] <= w_blk_q[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.valid_out   = r_valid_out;
    assign bus.dout_i      = r_dout_i;
    assign bus.dout_q      = r_dout_q;
    assign bus.frame_start = r_frame_start;
    assign bus.blk_idx     = r_blk_idx;
    assign bus.sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_in_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_in_packer
//  Description : Self-checking bench for fft_in_packer. The stimulus process
//                queues the expected block (or sync_err) with the cycle it
//                must appear in; a monitor on the falling edge pops and
//                compares whenever the DUT presents valid_out or sync_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_in_packer;

    localparam int W  = 11;
    localparam int N  = 16;
    localparam int FL = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fft_in_packer_if #(.IN_BIT_WIDTH(W), .N(N), .FRAME_LEN(FL)) bus ();

    fft_in_packer #(.IN_BIT_WIDTH(W), .N(N), .FRAME_LEN(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected block: element k is i = base+k, q = -(base+k)
    typedef struct {
        int base;
        int blk;
        bit fs;
        int cyc;
    } blk_exp_t;

    blk_exp_t exp_q[$];
    int       err_q[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else    $display("FAIL %s", msg);
    endfunction

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    blk_exp_t mon_e;
    int       mon_bad;
    int       mon_c;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, $sformatf("valid_out_unexpected cyc=%0d actual=1 required=0", cyc));
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_bad = -1;
                    for (int k = 0; k < N; k++) begin
                        if (mon_bad < 0 &&
                            ($signed(bus.dout_i[k]) != mon_e.base + k ||
                             $signed(bus.dout_q[k]) != -(mon_e.base + k)))
                            mon_bad = k;
                    end
                    if (mon_bad < 0) begin
                        chk(1'b1, "dout");
                    end else begin
                        chk(1'b0, $sformatf("dout blk=%0d k=%0d actual i=%0d q=%0d required i=%0d q=%0d",
                            mon_e.blk, mon_bad, $signed(bus.dout_i[mon_bad]),
                            $signed(bus.dout_q[mon_bad]), mon_e.base + mon_bad,
                            -(mon_e.base + mon_bad)));
                    end
                    chk(int'(bus.blk_idx) == mon_e.blk,
                        $sformatf("blk_idx actual=%0d required=%0d", bus.blk_idx, mon_e.blk));
                    chk(bus.frame_start == mon_e.fs,
                        $sformatf("frame_start blk=%0d actual=%0d required=%0d",
                                  mon_e.blk, bus.frame_start, mon_e.fs));
                    chk(cyc == mon_e.cyc,
                        $sformatf("valid_out_timing blk=%0d actual_cyc=%0d required_cyc=%0d",
                                  mon_e.blk, cyc, mon_e.cyc));
                end
            end
            if (bus.sync_err) begin
                if (err_q.size() == 0) begin
                    chk(1'b0, $sformatf("sync_err_unexpected cyc=%0d actual=1 required=0", cyc));
                end else begin
                    mon_c = err_q.pop_front();
                    chk(cyc == mon_c,
                        $sformatf("sync_err_timing actual_cyc=%0d required_cyc=%0d", cyc, mon_c));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic drive(input bit v, input bit s, input int val);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_i     = W'(val);
        bus.in_q     = W'(-val);
    endtask

    // Call right after driving the sample whose acceptance triggers the event
    task automatic push_blk(input int base, input int blk, input bit fs);
        blk_exp_t e;
        e.base = base;
        e.blk  = blk;
        e.fs   = fs;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        err_q.push_back(cyc + 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < N; k++)
            if (bus.dout_i[k] != '0 || bus.dout_q[k] != '0) nz++;
        chk(bus.valid_out == 1'b0,
            $sformatf("%s valid_out actual=%0d required=0", tag, bus.valid_out));
        chk(bus.sync_err == 1'b0,
            $sformatf("%s sync_err actual=%0d required=0", tag, bus.sync_err));
        chk(bus.frame_start == 1'b0,
            $sformatf("%s frame_start actual=%0d required=0", tag, bus.frame_start));
        chk(bus.blk_idx == '0,
            $sformatf("%s blk_idx actual=%0d required=0", tag, bus.blk_idx));
        chk(nz == 0,
            $sformatf("%s dout nonzero_elements actual=%0d required=0", tag, nz));
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_i     = '0;
        bus.in_q     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Full continuous frame: 32 blocks, one every 16 cycles
        for (int n = 0; n < FL; n++) begin
            drive(1'b1, n == 0, n);
            if (n % N == N - 1) push_blk(n - (N - 1), n / N, n < N);
        end

        // Same frame with in_valid toggling: pulses every 32 cycles
        for (int n = 0; n < FL; n++) begin
            drive(1'b1, n == 0, n);
            if (n % N == N - 1) push_blk(n - (N - 1), n / N, n < N);
            drive(1'b0, 1'b0, 0);
        end

        // Frame end followed by a sample without sync
        drive(1'b1, 1'b0, 7);
        push_err();

        // 40 unsynced samples are discarded silently
        for (int j = 0; j < 40; j++) drive(1'b1, 1'b0, -300 + j);

        // New frame, resync on sample 300 (inside block 18)
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, n == 0, n);
            if (n % N == N - 1) push_blk(n - (N - 1), n / N, n < N);
        end
        drive(1'b1, 1'b1, 300);
        push_err();
        for (int n = 301; n < 316; n++) begin
            drive(1'b1, 1'b0, n);
            if (n == 315) push_blk(300, 0, 1'b1);
        end

        // Resync landing on the slot that would complete a block
        for (int n = 316; n < 331; n++) drive(1'b1, 1'b0, n);
        drive(1'b1, 1'b1, 500);
        push_err();
        for (int n = 501; n < 516; n++) begin
            drive(1'b1, 1'b0, n);
            if (n == 515) push_blk(500, 0, 1'b1);
        end

        // Asynchronous reset after 10 samples of a block
        for (int j = 0; j < 10; j++) drive(1'b1, 1'b0, 600 + j);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Remaining 6 samples without sync must not produce a block
        for (int j = 0; j < 6; j++) drive(1'b1, 1'b0, 610 + j);
        drive(1'b0, 1'b0, 0);
        repeat (40) @(posedge clk);
        @(negedge clk);

        chk(exp_q.size() == 0,
            $sformatf("missing_valid_out actual_pending=%0d required=0", exp_q.size()));
        chk(err_q.size() == 0,
            $sformatf("missing_sync_err actual_pending=%0d required=0", err_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
